// File: rtl/prog_loader.sv
// Program-memory loader: byte stream (word-count header + 2 bytes/word) -> 14-bit write strobes.
// Optional trailing checksum byte enabled with `define PROG_LOADER_CKSUM_EN.
`timescale 1ns/1ps
module prog_loader #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 14,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [11:0]       words_written
);

    localparam int          HI_W    = DATA_W - 8;
    localparam logic [11:0] MAX_LEN = 12'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WRITE,
        S_DONE,
`ifdef PROG_LOADER_CKSUM_EN
        S_CHK,
`endif
        S_ERR
    } state_t;

`ifdef PROG_LOADER_CKSUM_EN
    localparam state_t FIN_STATE = S_CHK;
`else
    localparam state_t FIN_STATE = S_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [11:0]         r_len;
    logic [7:0]          r_lo;
    logic [ADDR_W-1:0]   r_addr_cnt;
    logic [11:0]         r_words;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]          r_sum;
`endif

    logic                w_acc;
    logic [11:0]         w_len;
    logic                w_hdr_bad;
    logic                w_hi_bad;
    logic                w_last;
    logic                w_start_ok;

    assign w_acc      = byte_valid && byte_ready;
    assign w_len      = {byte_in[3:0], r_len[7:0]};
    assign w_hdr_bad  = (byte_in[7:4] != 4'd0) || (w_len > MAX_LEN);
    assign w_hi_bad   = (byte_in[7:HI_W] != '0);
    assign w_last     = ((r_words + 12'd1) == r_len);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_LO;
            S_LEN_LO: if (w_acc) w_next = S_LEN_HI;
            S_LEN_HI: begin
                if (w_acc) begin
                    if (w_hdr_bad)          w_next = S_ERR;
                    else if (w_len == '0)   w_next = FIN_STATE;
                    else                    w_next = S_DAT_LO;
                end
            end
            S_DAT_LO: if (w_acc) w_next = S_DAT_HI;
            S_DAT_HI: if (w_acc) w_next = w_hi_bad ? S_ERR : S_WRITE;
            S_WRITE:  w_next = w_last ? FIN_STATE : S_DAT_LO;
`ifdef PROG_LOADER_CKSUM_EN
            S_CHK:    if (w_acc) w_next = (byte_in == r_sum) ? S_DONE : S_ERR;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
`ifdef PROG_LOADER_CKSUM_EN
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
`endif
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header length, low-byte latch, address/word counters and write registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_lo        <= '0;
            r_addr_cnt  <= '0;
            r_words     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_start_ok) begin
                r_addr_cnt <= '0;
                r_words    <= '0;
            end
            if (w_acc && (r_state == S_LEN_LO)) r_len[7:0]  <= byte_in;
            if (w_acc && (r_state == S_LEN_HI)) r_len[11:8] <= byte_in[3:0];
            if (w_acc && (r_state == S_DAT_LO)) r_lo        <= byte_in;
            if (w_acc && (r_state == S_DAT_HI) && !w_hi_bad) begin
                r_mem_wdata <= {byte_in[HI_W-1:0], r_lo};
                r_mem_addr  <= r_addr_cnt;
            end
            if (r_state == S_WRITE) begin
                r_addr_cnt <= r_addr_cnt + 1'b1;
                r_words    <= r_words + 12'd1;
            end
        end
    end

`ifdef PROG_LOADER_CKSUM_EN
    // Running sum of header and data bytes; the check byte itself is excluded.
    always_ff @(posedge clk) begin
        if (rst)                             r_sum <= '0;
        else if (w_start_ok)                 r_sum <= '0;
        else if (w_acc && (r_state != S_CHK)) r_sum <= r_sum + byte_in;
    end
`endif

    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign words_written = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a byte-count reference model.
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 14;
    localparam int MAX_WORDS = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [11:0]       words_written;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] s_q[$];
    logic [7:0] g_q[$];
    int         w_log[$];
    bit         g_rand = 1'b0;

    // Reference model: progress of a load expressed as bytes seen and words completed.
    bit         m_live = 1'b0;
    bit         m_active, m_done, m_err, m_pend, m_chk, m_have_lo;
    int         m_words, m_len, m_hdr, m_addr, m_wdata;
    logic [7:0] m_lo, m_sum;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_abort();
        m_active = 1'b0;
        m_err    = 1'b1;
        m_chk    = 1'b0;
        s_q.delete();
    endtask

    task automatic m_finish();
`ifdef PROG_LOADER_CKSUM_EN
        m_chk = 1'b1;
`else
        m_active = 1'b0;
        m_done   = 1'b1;
        s_q.delete();
`endif
    endtask

    task automatic model_step();
        logic [7:0] b;
        if (rst) begin
            m_active = 0; m_done = 0; m_err = 0; m_pend = 0; m_chk = 0; m_have_lo = 0;
            m_words = 0; m_len = 0; m_hdr = 0; m_addr = 0; m_wdata = 0; m_lo = 0; m_sum = 0;
            s_q.delete();
            m_live = 1'b1;
            return;
        end
        if (m_pend) begin
            m_pend = 1'b0;
            m_words++;
            if (m_words == m_len) m_finish();
            return;
        end
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_err = 0; m_chk = 0; m_have_lo = 0;
                m_words = 0; m_len = 0; m_hdr = 0; m_sum = 0;
            end
            return;
        end
        if (!byte_valid) return;
        b = byte_in;
        if (s_q.size() != 0) void'(s_q.pop_front());
        if (m_hdr == 0) begin
            m_len = int'(b); m_sum = m_sum + b; m_hdr = 1;
        end else if (m_hdr == 1) begin
            m_len = m_len + 256 * int'(b[3:0]); m_sum = m_sum + b; m_hdr = 2;
            if (b[7:4] != 4'd0 || m_len > MAX_WORDS) m_abort();
            else if (m_len == 0) m_finish();
        end else if (m_chk) begin
            m_active = 1'b0; m_chk = 1'b0;
            if (b == m_sum) m_done = 1'b1;
            else            m_err  = 1'b1;
        end else if (!m_have_lo) begin
            m_lo = b; m_have_lo = 1'b1; m_sum = m_sum + b;
        end else begin
            m_have_lo = 1'b0; m_sum = m_sum + b;
            if (b[7:6] != 2'd0) m_abort();
            else begin
                m_pend  = 1'b1;
                m_addr  = m_words;
                m_wdata = int'(b[5:0]) * 256 + int'(m_lo);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("byte_ready",    32'(byte_ready),    32'(m_active && !m_pend));
            check("mem_we",        32'(mem_we),        32'(m_pend));
            check("mem_addr",      32'(mem_addr),      32'(m_addr));
            check("mem_wdata",     32'(mem_wdata),     32'(m_wdata));
            check("busy",          32'(busy),          32'(m_active));
            check("done",          32'(done),          32'(m_done));
            check("err",           32'(err),           32'(m_err));
            check("words_written", 32'(words_written), 32'(m_words));
            if (mem_we === 1'b1) w_log.push_back(int'(mem_addr) * 65536 + int'(mem_wdata));
        end
    end

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
        if (s_q.size() != 0) begin
            byte_in    = s_q[0];
            byte_valid = g_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            byte_in    = 8'($urandom);
            byte_valid = 1'b0;
        end
    endtask

    task automatic run(input bit ck, input int budget);
`ifdef PROG_LOADER_CKSUM_EN
        logic [7:0] s;
        if (ck) begin
            s = 8'h00;
            foreach (g_q[i]) s = s + g_q[i];
            g_q.push_back(s);
        end
`endif
        w_log.delete();
        tick();
        start = 1'b1;
        s_q   = g_q;
        tick();
        for (int i = 0; i < budget && m_active; i++) begin
            tick();
            if (g_rand && m_active && $urandom_range(0, 19) == 0) start = 1'b1;
        end
        if (m_active) begin
            check("load_timeout", 32'(m_active), 32'd0);
            rst = 1'b1; tick(); rst = 1'b0; tick();
        end
    endtask

    task automatic build(input int n, input bit corrupt);
        logic [7:0] hi;
        g_q.delete();
        g_q.push_back(8'(n));
        g_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            hi = {2'b00, 6'($urandom)};
            if (corrupt && i == n / 2) hi[7:6] = 2'($urandom_range(1, 3));
            g_q.push_back(8'($urandom));
            g_q.push_back(hi);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_ready", 32'(byte_ready), 32'd0);
        check("reset_busy",  32'(busy),       32'd0);
        check("reset_ww",    32'(words_written), 32'd0);

        g_rand = 1'b0;
        g_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hFF, 8'h3F};
        run(1'b1, 100);
        check("t1_nwrites", 32'(w_log.size()), 32'd2);
        check("t1_w0",      32'(w_log[0]), 32'h0000_1234);
        check("t1_w1",      32'(w_log[1]), 32'h0001_3FFF);
        check("t1_done",    32'(done), 32'd1);
        check("t1_ww",      32'(words_written), 32'd2);
        check("t1_ready",   32'(byte_ready), 32'd0);

        g_q = '{8'h00, 8'h00};
        run(1'b1, 50);
        check("t2_done",    32'(done), 32'd1);
        check("t2_ww",      32'(words_written), 32'd0);
        check("t2_nwrites", 32'(w_log.size()), 32'd0);

        g_q = '{8'h01, 8'h00, 8'h55, 8'h40};
        run(1'b0, 50);
        check("t3_err",     32'(err), 32'd1);
        check("t3_nwrites", 32'(w_log.size()), 32'd0);
        g_q = '{8'h01, 8'h00, 8'hAA, 8'h15};
        run(1'b1, 50);
        check("t3b_done",   32'(done), 32'd1);
        check("t3b_err",    32'(err), 32'd0);
        check("t3b_w0",     32'(w_log[0]), 32'h0000_15AA);

        g_q = '{8'h01, 8'h08};
        run(1'b0, 50);
        check("t4_len2049_err", 32'(err), 32'd1);
        g_q = '{8'h01, 8'h10};
        run(1'b0, 50);
        check("t4_hibits_err",  32'(err), 32'd1);

        build(2048, 1'b0);
        run(1'b1, 7000);
        check("t5_done",    32'(done), 32'd1);
        check("t5_ww",      32'(words_written), 32'd2048);
        check("t5_nwrites", 32'(w_log.size()), 32'd2048);
        check("t5_lastaddr", 32'(w_log[2047] / 65536), 32'd2047);

`ifdef PROG_LOADER_CKSUM_EN
        g_q = '{8'h01, 8'h00, 8'h10, 8'h01, 8'h12};
        run(1'b0, 50);
        check("ck_done",    32'(done), 32'd1);
        check("ck_w0",      32'(w_log[0]), 32'h0000_0110);
        g_q = '{8'h01, 8'h00, 8'h10, 8'h01, 8'h13};
        run(1'b0, 50);
        check("ck_err",     32'(err), 32'd1);
        check("ck_err_w0",  32'(w_log[0]), 32'h0000_0110);
`endif

        g_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            build($urandom_range(1, 16), ($urandom_range(0, 9) == 0));
            run(1'b1, 400);
        end

        build(5, 1'b0);
        w_log.delete();
        tick();
        start = 1'b1;
        s_q   = g_q;
        tick();
        for (int i = 0; i < 500 && m_words < 3; i++) tick();
        check("rst_reach3", 32'(m_words), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ww",    32'(words_written), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        repeat (6) tick();
        check("rst_nwrites", 32'(w_log.size()), 32'd3);

        build(2, 1'b0);
        run(1'b1, 200);
        check("restart_done",  32'(done), 32'd1);
        check("restart_addr0", 32'(w_log[0] / 65536), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
